// File: rtl/pkg_opengpu.sv
// Shared GPU front-end types: warp slot state, warp context and bus widths.
// Widths here fix the port sizes of the warp scheduler and its arbiter.
package pkg_opengpu;

  localparam int WARP_ID_WIDTH     = 2;
  localparam int DEFAULT_NUM_WARPS = 2 ** WARP_ID_WIDTH;
  localparam int WARP_SIZE         = 32;
  localparam int DATA_WIDTH        = 32;

  typedef enum logic [1:0] {
    W_IDLE     = 2'd0,
    W_READY    = 2'd1,
    W_INFLIGHT = 2'd2,
    W_DONE     = 2'd3
  } warp_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [WARP_SIZE-1:0]  mask;
  } warp_ctx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after base, wrapping; one-hot grant plus index.
// Purely combinational, no state; an all-zero request vector yields an all-zero grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;
  logic          found;

  // N is a power of two, so the IW-bit add wraps exactly at N.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = base + IW'(i);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/simt_warp_scheduler.sv
// Warp slot table with a registered round-robin offer to fetch; READY-to-offer latency is one cycle.
// The offer holds until issue_ack or flush (flush wins); launches stall via launch_ready on busy slots.
module simt_warp_scheduler
  import pkg_opengpu::*;
#(
  parameter int NUM_WARPS = DEFAULT_NUM_WARPS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     launch_valid,
  input  logic [WARP_ID_WIDTH-1:0] launch_warp_id,
  input  logic [DATA_WIDTH-1:0]    launch_pc,
  input  logic [WARP_SIZE-1:0]     launch_mask,
  output logic                     launch_ready,
  output logic                     warp_valid,
  output logic [WARP_ID_WIDTH-1:0] warp_id,
  output logic [DATA_WIDTH-1:0]    warp_pc,
  output logic [WARP_SIZE-1:0]     warp_mask,
  input  logic                     issue_ack,
  input  logic                     resolve_valid,
  input  logic [WARP_ID_WIDTH-1:0] resolve_warp_id,
  input  logic [DATA_WIDTH-1:0]    resolve_next_pc,
  input  logic [WARP_SIZE-1:0]     resolve_mask,
  input  logic                     resolve_exit,
  output logic [NUM_WARPS-1:0]     active_warps,
  output logic                     all_done
);

  warp_state_t state_q [NUM_WARPS];
  warp_state_t state_d [NUM_WARPS];
  warp_ctx_t   ctx_q   [NUM_WARPS];
  warp_ctx_t   ctx_d   [NUM_WARPS];

  logic [WARP_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                     offer_vld_q, offer_vld_d;
  logic [WARP_ID_WIDTH-1:0] offer_id_q, offer_id_d;
  warp_ctx_t                offer_ctx_q, offer_ctx_d;
  logic                     done_seen_q, done_seen_d;

  logic [NUM_WARPS-1:0]     ready_vec;
  logic [NUM_WARPS-1:0]     grant;
  logic [WARP_ID_WIDTH-1:0] grant_idx;
  warp_ctx_t                grant_ctx;
  logic                     res_hit;
  logic                     res_retire;
  logic                     ack_take;

  rr_arbiter #(
    .N  (NUM_WARPS),
    .IW (WARP_ID_WIDTH)
  ) u_rr_arbiter (
    .req   (ready_vec),
    .base  (rr_ptr_q),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign launch_ready = (state_q[launch_warp_id] == W_IDLE) ||
                        (state_q[launch_warp_id] == W_DONE);
  assign res_hit      = resolve_valid && (state_q[resolve_warp_id] == W_INFLIGHT);
  assign res_retire   = resolve_exit || (resolve_mask == '0);
  assign ack_take     = issue_ack && offer_vld_q;

  always_comb begin
    ready_vec = '0;
    grant_ctx = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      ready_vec[i] = (state_q[i] == W_READY);
      if (grant[i]) grant_ctx = grant_ctx | ctx_q[i];
    end
  end

  // An INFLIGHT slot never has launch_ready, so resolve and launch cannot collide on a slot.
  always_comb begin
    state_d     = state_q;
    ctx_d       = ctx_q;
    rr_ptr_d    = rr_ptr_q;
    offer_vld_d = offer_vld_q;
    offer_id_d  = offer_id_q;
    offer_ctx_d = offer_ctx_q;
    done_seen_d = done_seen_q;

    if (launch_valid && launch_ready) begin
      state_d[launch_warp_id] = W_READY;
      ctx_d[launch_warp_id]   = '{pc: launch_pc, mask: launch_mask};
    end

    if (res_hit) begin
      if (res_retire) begin
        state_d[resolve_warp_id] = W_DONE;
        done_seen_d              = 1'b1;
      end else begin
        state_d[resolve_warp_id] = W_READY;
        ctx_d[resolve_warp_id]   = '{pc: resolve_next_pc, mask: resolve_mask};
      end
    end

    if (flush) begin
      offer_vld_d = 1'b0;
    end else if (ack_take) begin
      state_d[offer_id_q] = W_INFLIGHT;
      rr_ptr_d            = offer_id_q + WARP_ID_WIDTH'(1);
      offer_vld_d         = 1'b0;
    end else if (!offer_vld_q && enable && (|grant)) begin
      offer_vld_d = 1'b1;
      offer_id_d  = grant_idx;
      offer_ctx_d = grant_ctx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        state_q[i] <= W_IDLE;
        ctx_q[i]   <= '0;
      end
      rr_ptr_q    <= '0;
      offer_vld_q <= 1'b0;
      offer_id_q  <= '0;
      offer_ctx_q <= '0;
      done_seen_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        state_q[i] <= state_d[i];
        ctx_q[i]   <= ctx_d[i];
      end
      rr_ptr_q    <= rr_ptr_d;
      offer_vld_q <= offer_vld_d;
      offer_id_q  <= offer_id_d;
      offer_ctx_q <= offer_ctx_d;
      done_seen_q <= done_seen_d;
    end
  end

  always_comb begin
    warp_valid   = offer_vld_q;
    warp_id      = offer_id_q;
    warp_pc      = offer_ctx_q.pc;
    warp_mask    = offer_ctx_q.mask;
    active_warps = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      active_warps[i] = (state_q[i] == W_READY) || (state_q[i] == W_INFLIGHT);
    end
    all_done = done_seen_q && (active_warps == '0);
  end

endmodule

// File: tb/tb_simt_warp_scheduler.sv
// Directed scenarios plus random traffic, every cycle compared against a slot-table reference model.
module tb_simt_warp_scheduler;
  import pkg_opengpu::*;

  localparam int NW = DEFAULT_NUM_WARPS;
  localparam int S_IDLE = 0, S_READY = 1, S_FLIGHT = 2, S_DONE = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     enable, flush, launch_valid, launch_ready;
  logic [WARP_ID_WIDTH-1:0] launch_warp_id, warp_id, resolve_warp_id;
  logic [DATA_WIDTH-1:0]    launch_pc, warp_pc, resolve_next_pc;
  logic [WARP_SIZE-1:0]     launch_mask, warp_mask, resolve_mask;
  logic                     warp_valid, issue_ack, resolve_valid, resolve_exit;
  logic [NW-1:0]            active_warps;
  logic                     all_done;

  int errors = 0;
  int checks = 0;

  // Reference model: abstract slot table and the current offer.
  int          mst   [NW];
  logic [31:0] mpc   [NW];
  logic [31:0] mmask [NW];
  bit          mvld;
  int          mid;
  logic [31:0] mopc, momask;
  int          mrr;
  bit          mseen;

  always #5 clk = ~clk;

  simt_warp_scheduler #(.NUM_WARPS(NW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .flush           (flush),
    .launch_valid    (launch_valid),
    .launch_warp_id  (launch_warp_id),
    .launch_pc       (launch_pc),
    .launch_mask     (launch_mask),
    .launch_ready    (launch_ready),
    .warp_valid      (warp_valid),
    .warp_id         (warp_id),
    .warp_pc         (warp_pc),
    .warp_mask       (warp_mask),
    .issue_ack       (issue_ack),
    .resolve_valid   (resolve_valid),
    .resolve_warp_id (resolve_warp_id),
    .resolve_next_pc (resolve_next_pc),
    .resolve_mask    (resolve_mask),
    .resolve_exit    (resolve_exit),
    .active_warps    (active_warps),
    .all_done        (all_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      mst[i] = S_IDLE; mpc[i] = '0; mmask[i] = '0;
    end
    mvld = 0; mid = 0; mopc = '0; momask = '0; mrr = 0; mseen = 0;
  endtask

  function automatic logic [NW-1:0] exp_active();
    logic [NW-1:0] v;
    v = '0;
    for (int i = 0; i < NW; i++) v[i] = (mst[i] == S_READY) || (mst[i] == S_FLIGHT);
    return v;
  endfunction

  // Applies one clock edge worth of the behavioural rules to the model.
  task automatic model_step();
    int  nst [NW];
    bit  acc;
    int  lid, rid, k;
    for (int i = 0; i < NW; i++) nst[i] = mst[i];
    acc = issue_ack && mvld && !flush;
    lid = int'(launch_warp_id);
    rid = int'(resolve_warp_id);
    if (launch_valid && (mst[lid] == S_IDLE || mst[lid] == S_DONE)) begin
      nst[lid] = S_READY; mpc[lid] = launch_pc; mmask[lid] = launch_mask;
    end
    if (resolve_valid && mst[rid] == S_FLIGHT) begin
      if (resolve_exit || resolve_mask == 0) begin
        nst[rid] = S_DONE; mseen = 1;
      end else begin
        nst[rid] = S_READY; mpc[rid] = resolve_next_pc; mmask[rid] = resolve_mask;
      end
    end
    if (flush) begin
      mvld = 0;
    end else if (acc) begin
      nst[mid] = S_FLIGHT; mrr = (mid + 1) % NW; mvld = 0;
    end else if (!mvld && enable) begin
      for (int j = 0; j < NW; j++) begin
        k = (mrr + j) % NW;
        if (!mvld && mst[k] == S_READY) begin
          mvld = 1; mid = k; mopc = mpc[k]; momask = mmask[k];
        end
      end
    end
    for (int i = 0; i < NW; i++) mst[i] = nst[i];
  endtask

  // Called just after a falling edge with inputs already set; returns at the next falling edge.
  task automatic cyc();
    #1;
    chk("warp_valid", warp_valid, mvld);
    if (mvld) begin
      chk("warp_id", warp_id, mid);
      chk("warp_pc", warp_pc, mopc);
      chk("warp_mask", warp_mask, momask);
    end
    chk("active_warps", active_warps, exp_active());
    chk("all_done", all_done, mseen && (exp_active() == '0));
    chk("launch_ready", launch_ready,
        mst[launch_warp_id] == S_IDLE || mst[launch_warp_id] == S_DONE);
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    enable = 1'b1; flush = 1'b0; issue_ack = 1'b0;
    launch_valid = 1'b0; launch_warp_id = '0; launch_pc = '0; launch_mask = '0;
    resolve_valid = 1'b0; resolve_warp_id = '0; resolve_next_pc = '0;
    resolve_mask = '0; resolve_exit = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic launch(input int id, input logic [31:0] pc, input logic [31:0] mask);
    launch_valid = 1'b1; launch_warp_id = WARP_ID_WIDTH'(id);
    launch_pc = pc; launch_mask = mask;
  endtask

  task automatic resolve(input int id, input logic [31:0] pc, input logic [31:0] mask, input bit ex);
    resolve_valid = 1'b1; resolve_warp_id = WARP_ID_WIDTH'(id);
    resolve_next_pc = pc; resolve_mask = mask; resolve_exit = ex;
  endtask

  initial begin
    int order[$];
    int prev;
    logic [31:0] prevpc;
    int fl[$];

    idle();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_warp_valid", warp_valid, 0);
    chk("rst_warp_id", warp_id, 0);
    chk("rst_warp_pc", warp_pc, 0);
    chk("rst_warp_mask", warp_mask, 0);
    chk("rst_active", active_warps, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_launch_ready", launch_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Launch to offer takes two edges; offer then holds while unacknowledged.
    launch(2, 32'h100, 32'hFFFF_FFFF);
    cyc();
    idle();
    cyc();
    chk("t032_valid", warp_valid, 1);
    chk("t032_id", warp_id, 2);
    chk("t032_pc", warp_pc, 32'h100);
    repeat (5) cyc();
    chk("t034_hold_pc", warp_pc, 32'h100);
    chk("t034_hold_mask", warp_mask, 32'hFFFF_FFFF);
    issue_ack = 1'b1;
    cyc();
    idle();
    chk("t034_valid_after_ack", warp_valid, 0);
    launch_warp_id = 2'd2;
    #1 chk("t034_inflight_not_ready", launch_ready, 0);
    cyc();
    cyc();
    chk("t034_no_reoffer", warp_valid, 0);

    // Round-robin order with ack on every offer and resolve one cycle later.
    do_reset();
    prev = -1;
    prevpc = '0;
    for (int c = 0; c < 24; c++) begin
      idle();
      if (c < 4) launch(c, 32'h0, 32'hFFFF_FFFF);
      if (prev >= 0) resolve(prev, prevpc + 32'd4, 32'hFFFF_FFFF, 1'b0);
      prev = -1;
      if (warp_valid) begin
        issue_ack = 1'b1;
        order.push_back(int'(warp_id));
        prev = int'(warp_id);
        prevpc = warp_pc;
      end
      cyc();
    end
    idle();
    chk("t033_offer_count", order.size() >= 6, 1);
    for (int k = 0; k < 6 && k < order.size(); k++) chk("t033_order", order[k], k % 4);

    // Flush beats a same-cycle ack; the slot is re-offered with its pc.
    do_reset();
    launch(1, 32'h40, 32'h0000_00FF);
    cyc();
    idle();
    cyc();
    chk("t035_offered", warp_valid, 1);
    flush = 1'b1;
    issue_ack = 1'b1;
    cyc();
    idle();
    chk("t035_valid_dropped", warp_valid, 0);
    cyc();
    chk("t035_reoffer_valid", warp_valid, 1);
    chk("t035_reoffer_id", warp_id, 1);
    chk("t035_reoffer_pc", warp_pc, 32'h40);

    // Exit and empty-mask retirement, then a resolve to a DONE slot.
    do_reset();
    launch(0, 32'h10, 32'h1);
    cyc();
    launch(1, 32'h20, 32'h3);
    cyc();
    idle();
    for (int c = 0; c < 8; c++) begin
      issue_ack = warp_valid;
      cyc();
    end
    idle();
    resolve(0, 32'h14, 32'h1, 1'b1);
    cyc();
    resolve(1, 32'h24, 32'h0, 1'b0);
    cyc();
    idle();
    chk("t036_all_done", all_done, 1);
    chk("t036_active", active_warps, 0);
    resolve(0, 32'h80, 32'hF, 1'b0);
    cyc();
    idle();
    cyc();
    chk("t036_done_ignored_active", active_warps, 0);
    chk("t036_done_ignored_valid", warp_valid, 0);

    // Asynchronous reset while warp 3 is in flight.
    do_reset();
    launch(3, 32'h300, 32'hF0F0_F0F0);
    cyc();
    idle();
    cyc();
    issue_ack = 1'b1;
    cyc();
    idle();
    chk("t037_inflight", active_warps, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    chk("t037_async_valid", warp_valid, 0);
    chk("t037_async_active", active_warps, 0);
    chk("t037_async_pc", warp_pc, 0);
    chk("t037_async_mask", warp_mask, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    resolve(3, 32'h304, 32'hFFFF, 1'b0);
    cyc();
    idle();
    cyc();
    chk("t037_resolve_ignored", active_warps, 0);
    chk("t037_no_offer", warp_valid, 0);

    // Random traffic checked cycle by cycle against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      idle();
      enable = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 9) == 0);
      issue_ack = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 2) == 0)
        launch($urandom_range(0, NW - 1), $urandom, $urandom);
      if ($urandom_range(0, 1) == 1) begin
        fl.delete();
        for (int i = 0; i < NW; i++) if (mst[i] == S_FLIGHT) fl.push_back(i);
        resolve((fl.size() > 0 && $urandom_range(0, 3) != 0) ?
                  fl[$urandom_range(0, fl.size() - 1)] : $urandom_range(0, NW - 1),
                $urandom,
                ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom,
                $urandom_range(0, 5) == 0);
      end
      cyc();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simt_warp_scheduler.md
SIMT_WARP_SCHEDULER -- requirements
Module: simt_warp_scheduler

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of warp slots (power of 2, equals 2**WARP_ID_WIDTH).
REQ-002 SHALL have clk  input  1  clock; one clock domain, rising edge.
REQ-003 SHALL have rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have enable  input  1  scheduling enable; when low, no new offer is made.
REQ-005 SHALL have flush  input  1  withdraws the current offer.
REQ-006 SHALL have launch_valid / launch_warp_id / launch_pc / launch_mask  input  1 / WARP_ID_WIDTH / DATA_WIDTH / WARP_SIZE  warp launch request.
REQ-007 SHALL have launch_ready  output  1  high when the addressed slot can accept a launch.
REQ-008 SHALL have warp_valid / warp_id / warp_pc / warp_mask  output  1 / WARP_ID_WIDTH / DATA_WIDTH / WARP_SIZE  offer to fetch stage.
REQ-009 SHALL have issue_ack  input  1  fetch accepted the current offer.
REQ-010 SHALL have resolve_valid / resolve_warp_id / resolve_next_pc / resolve_mask / resolve_exit  input  1 / WARP_ID_WIDTH / DATA_WIDTH / WARP_SIZE / 1  instruction completion from writeback.
REQ-011 SHALL have active_warps  output  NUM_WARPS  per-slot busy flags (READY or INFLIGHT).
REQ-012 SHALL have all_done  output  1  high when no slot is READY or INFLIGHT and at least one warp has completed since reset.

Function
REQ-013 Each slot SHALL hold state {W_IDLE, W_READY, W_INFLIGHT, W_DONE}, pc and mask.
REQ-014 Launch SHALL be accepted only when the target slot is W_IDLE or W_DONE: slot -> W_READY with launch_pc/launch_mask at the next edge.
REQ-015 launch_ready SHALL be combinational: high iff slot launch_warp_id is W_IDLE or W_DONE.
REQ-016 Offer register: when warp_valid is low, enable is high and flush is low, the scheduler SHALL select a W_READY slot round-robin starting at rr_ptr and register warp_valid/id/pc/mask next cycle (1-cycle latency from READY to offer).
REQ-017 The offer SHALL remain stable (all four outputs unchanged) until issue_ack or flush.
REQ-018 On issue_ack with warp_valid high: the offered slot -> W_INFLIGHT; rr_ptr = offered id + 1 (mod NUM_WARPS); warp_valid low next cycle.
REQ-019 At most one offer per two cycles per design; no back-to-back re-offer of the same slot (it is INFLIGHT).
REQ-020 issue_ack while warp_valid is low SHALL be ignored.
REQ-021 flush SHALL clear warp_valid next cycle; the offered slot stays W_READY; rr_ptr unchanged; flush has priority over a same-cycle issue_ack.
REQ-022 Resolve to a W_INFLIGHT slot: if resolve_exit or resolve_mask == 0, slot -> W_DONE; else slot -> W_READY with pc = resolve_next_pc, mask = resolve_mask.
REQ-023 Resolve to a slot not in W_INFLIGHT SHALL be ignored.
REQ-024 Launch and resolve in the same cycle to the same slot: resolve wins and launch is dropped (launch_ready is low for an INFLIGHT slot).
REQ-025 Launch, resolve and issue_ack to different slots in the same cycle SHALL all take effect.
REQ-026 A slot becoming W_READY in cycle N SHALL be eligible for selection in cycle N+1.
REQ-027 When no slot is W_READY, warp_valid SHALL stay low; rr_ptr SHALL not change.

Reset
REQ-028 On rst_n low, SHALL immediately reset: all slots W_IDLE, pc 0, mask 0, rr_ptr 0, warp_valid 0, warp_id/pc/mask 0, all_done 0, done-seen flag 0.
REQ-029 Reset mid-offer or mid-flight SHALL discard all warps; no resolve is honoured until relaunch.

Structure
REQ-030 warp_state_t enum and NUM_WARPS default SHALL live in pkg_opengpu beside WARP_ID_WIDTH, WARP_SIZE and DATA_WIDTH.
REQ-031 The round-robin picker SHALL be a sub-module rr_arbiter (NUM_WARPS request vector, base pointer in, one-hot grant and index out, purely combinational).

Verification
REQ-032 Launch warp 2, pc 0x100, mask 0xFFFF_FFFF -> warp_valid rises 2 cycles later with warp_id 2, warp_pc 0x100.
REQ-033 Launch warps 0 to 3 at pc 0x0 with ack every offer and immediate resolve (next_pc +4) -> offer order 0,1,2,3,0,1...
REQ-034 Hold issue_ack low 5 cycles during an offer -> warp_id/pc/mask are constant; ack -> slot INFLIGHT, warp_valid low next cycle.
REQ-035 flush and issue_ack together on warp 1 -> warp_valid low next cycle, warp 1 still READY and re-offered with the same pc.
REQ-036 Resolve warp 0 with resolve_exit=1, then resolve warp 1 with mask 0 -> both W_DONE; all_done=1 when no other warps are active; a resolve to a DONE slot is ignored.
REQ-037 Assert rst_n low while warp 3 is INFLIGHT -> all outputs 0 asynchronously; a later resolve to warp 3 has no effect.
